ram_dp_param: RTL and testbench

- Parametrised simple dual-port synchronous RAM with one write port and one read port on a single clock.
- Next-generation memory primitive for the behavioural library. Generalises the fixed 16x8 dual-port RAM in data width and depth.
- Adds per-byte write enables, selectable read latency, a defined read-during-write policy, a read-valid output, and a sequential zero-initialisation engine after reset.

---
 rtl/ram_dp_param.sv | 174 +++++++++++++++++
 tb/tb_ram_dp_param.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_param.sv
// ram_dp_param - simple dual-port synchronous RAM, one write port and one
// read port on a single clock.
//
// Parameters:
//   DATA_W   word width in bits (multiple of 8)
//   ADDR_W   address width, depth is 2**ADDR_W
//   RD_LAT   read latency in clock edges (1 or 2)
//   RDW_MODE same-address read/write: 0 = old data, 1 = new (merged) data
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active low
//   wr_en      write request
//   wr_addr    write address
//   wr_be      byte-lane write enables, bit k covers din[8k+7:8k]
//   din        write data
//   rd_en      read request
//   rd_addr    read address
//   dout       registered read data, holds its value between reads
//   rd_valid   one-cycle pulse when dout carries data for an accepted read
//   init_busy  high while the array is being zero-filled after reset;
//              both ports are ignored during this time
//
// State table:
//   ST_INIT  | clearing mem[ptr] to zero each cycle, ports ignored
//   ST_READY | normal operation
module ram_dp_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [DATA_W-1:0]     din,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     dout,
    output logic                  rd_valid,
    output logic                  init_busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   ptr, ptr_nx;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                wr_go;
    logic                rd_go;
    logic [DATA_W-1:0]   wr_merged;
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   out_data;
    logic                out_go;

    // ---------------------------------------------------------------
    // Clear-sequencing FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_INIT;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        case (state)
            ST_INIT: begin
                ptr_nx = ptr + 1'b1;
                if (ptr == '1) begin
                    state_nx = ST_READY;
                end
            end
            ST_READY: begin
                ptr_nx = '0;
            end
            default: begin
                state_nx = ST_INIT;
                ptr_nx   = '0;
            end
        endcase
    end

    assign init_busy = (state == ST_INIT);
    assign wr_go     = wr_en && (state == ST_READY);
    assign rd_go     = rd_en && (state == ST_READY);

    // ---------------------------------------------------------------
    // Write path: merge enabled byte lanes into the stored word
    // ---------------------------------------------------------------
    always_comb begin
        wr_merged = mem[wr_addr];
        for (int k = 0; k < NB; k++) begin
            if (wr_be[k]) begin
                wr_merged[8*k +: 8] = din[8*k +: 8];
            end
        end
    end

    // The array has no reset; it is only written once rst is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == ST_INIT) begin
                mem[ptr] <= '0;
            end else if (wr_go) begin
                mem[wr_addr] <= wr_merged;
            end
        end
    end

    // ---------------------------------------------------------------
    // Read path
    // ---------------------------------------------------------------
    // Write-first bypass: a same-edge write to the read address returns
    // the merged word, so unwritten lanes still show the old bytes.
    always_comb begin
        rd_word = mem[rd_addr];
        if ((RDW_MODE == 1) && wr_go && (wr_addr == rd_addr)) begin
            rd_word = wr_merged;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] s1_data;
            logic              s1_valid;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    s1_data  <= '0;
                    s1_valid <= 1'b0;
                end else begin
                    s1_valid <= rd_go;
                    if (rd_go) begin
                        s1_data <= rd_word;
                    end
                end
            end

            assign out_data = s1_data;
            assign out_go   = s1_valid;
        end else begin : g_lat1
            assign out_data = rd_word;
            assign out_go   = rd_go;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            dout     <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= out_go;
            if (out_go) begin
                dout <= out_data;
            end
        end
    end

endmodule

// File: tb/tb_ram_dp_param.sv
module tb_ram_dp_param;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [1:0]  wr_be;
    logic [15:0] din;
    logic        rd_en;
    logic [3:0]  rd_addr;

    logic [7:0]  dout_a;
    logic        rd_valid_a;
    logic        init_busy_a;
    logic [15:0] dout_b;
    logic        rd_valid_b;
    logic        init_busy_b;

    // a: 8-bit, latency 1, read-first.  b: 16-bit, latency 2, write-first.
    ram_dp_param #(.DATA_W(8), .ADDR_W(4), .RD_LAT(1), .RDW_MODE(0)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_be     (wr_be[0:0]),
        .din       (din[7:0]),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .dout      (dout_a),
        .rd_valid  (rd_valid_a),
        .init_busy (init_busy_a)
    );

    ram_dp_param #(.DATA_W(16), .ADDR_W(4), .RD_LAT(2), .RDW_MODE(1)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_be     (wr_be),
        .din       (din),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .dout      (dout_b),
        .rd_valid  (rd_valid_b),
        .init_busy (init_busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [15:0] qa_d[$];
    int          qa_c[$];
    logic [15:0] qb_d[$];
    int          qb_c[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Response collector: records every rd_valid pulse with its edge number.
    always @(posedge clk) begin
        #2;
        if (rd_valid_a === 1'b1) begin
            qa_d.push_back({8'h00, dout_a});
            qa_c.push_back(cyc);
        end
        if (rd_valid_b === 1'b1) begin
            qb_d.push_back(dout_b);
            qb_c.push_back(cyc);
        end
    end

    typedef struct {
        bit          wr;
        bit          rd;
        logic [3:0]  wa;
        logic [3:0]  ra;
        logic [15:0] d;
        logic [1:0]  be;
        logic [7:0]  ea;
        logic [15:0] eb;
    } vec_t;

    vec_t tbl[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_q();
        qa_d.delete();
        qa_c.delete();
        qb_d.delete();
        qb_c.delete();
    endtask

    task automatic idle_inputs();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_addr = '0;
        rd_addr = '0;
        din     = '0;
        wr_be   = '0;
    endtask

    function automatic logic [7:0] fv(input int i);
        return 8'((i * 17 + 3) & 255);
    endfunction

    // Counts init_busy cycles of both instances; optionally pokes both
    // ports a couple of times while the clear is running.
    task automatic run_init(output int na, output int nb, input bit poke);
        int n;
        n  = 0;
        na = 0;
        nb = 0;
        while ((init_busy_a || init_busy_b) && n < 40) begin
            if (init_busy_a) na++;
            if (init_busy_b) nb++;
            idle_inputs();
            if (poke && n == 3) begin
                wr_en = 1'b1; wr_addr = 4'd15; din = 16'hFFFF; wr_be = 2'b11;
                rd_en = 1'b1; rd_addr = 4'd15;
            end
            if (poke && n == 5) begin
                wr_en = 1'b1; wr_addr = 4'd0; din = 16'hFFFF; wr_be = 2'b11;
                rd_en = 1'b1; rd_addr = 4'd0;
            end
            n++;
            tick();
        end
        idle_inputs();
    endtask

    task automatic stream_reads(input bit zero);
        int s;
        logic [15:0] ea, eb;
        clear_q();
        s = cyc + 1;
        for (int i = 0; i < 16; i++) begin
            rd_en   = 1'b1;
            rd_addr = 4'(i);
            tick();
        end
        idle_inputs();
        repeat (4) tick();
        chk("stream_count_a", qa_d.size(), 16);
        chk("stream_count_b", qb_d.size(), 16);
        for (int i = 0; i < 16; i++) begin
            ea = zero ? 16'h0000 : {8'h00, fv(i)};
            eb = zero ? 16'h0000 : {~fv(i), fv(i)};
            if (i < qa_d.size()) begin
                chk("stream_data_a", qa_d[i], ea);
                chk("stream_lat_a", qa_c[i], s + i);
            end
            if (i < qb_d.size()) begin
                chk("stream_data_b", qb_d[i], eb);
                chk("stream_lat_b", qb_c[i], s + i + 1);
            end
        end
    endtask

    initial begin
        int na, nb, s;
        idle_inputs();
        rst = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_dout_a", dout_a, 8'h00);
        chk("rst_dout_b", dout_b, 16'h0000);
        chk("rst_valid_a", rd_valid_a, 1'b0);
        chk("rst_valid_b", rd_valid_b, 1'b0);
        chk("rst_busy_a", init_busy_a, 1'b1);
        chk("rst_busy_b", init_busy_b, 1'b1);

        // Initial clear with accesses attempted during INIT
        clear_q();
        rst = 1'b1;
        run_init(na, nb, 1'b1);
        chk("init_cycles_a", na, 16);
        chk("init_cycles_b", nb, 16);
        tick();
        chk("init_no_valid_a", qa_d.size(), 0);
        chk("init_no_valid_b", qb_d.size(), 0);
        chk("init_dout_a", dout_a, 8'h00);
        chk("init_dout_b", dout_b, 16'h0000);
        stream_reads(1'b1);

        // Fill and stream readback
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_addr = 4'(i);
            din     = {~fv(i), fv(i)};
            wr_be   = 2'b11;
            tick();
        end
        idle_inputs();
        tick();
        stream_reads(1'b0);
        chk("stream_first_a", qa_d.size() > 0 ? qa_d[0] : 16'hDEAD, 16'h0003);
        chk("stream_second_a", qa_d.size() > 1 ? qa_d[1] : 16'hDEAD, 16'h0014);
        chk("hold_dout_a", dout_a, 8'h02);
        chk("hold_dout_b", dout_b, 16'hFD02);
        chk("hold_valid_a", rd_valid_a, 1'b0);
        chk("hold_valid_b", rd_valid_b, 1'b0);

        // Directed single-operation vectors
        //                 wr    rd    wa     ra     din       be     exp_a  exp_b
        tbl.push_back('{1'b1, 1'b0, 4'd5,  4'd0,  16'hABCD, 2'b11, 8'h00, 16'h0000});
        tbl.push_back('{1'b1, 1'b0, 4'd5,  4'd0,  16'h1234, 2'b01, 8'h00, 16'h0000});
        tbl.push_back('{1'b0, 1'b1, 4'd0,  4'd5,  16'h0000, 2'b00, 8'h34, 16'hAB34});
        tbl.push_back('{1'b1, 1'b0, 4'd5,  4'd0,  16'h5678, 2'b10, 8'h00, 16'h0000});
        tbl.push_back('{1'b0, 1'b1, 4'd0,  4'd5,  16'h0000, 2'b00, 8'h34, 16'h5634});
        tbl.push_back('{1'b1, 1'b0, 4'd5,  4'd0,  16'hFFFF, 2'b00, 8'h00, 16'h0000});
        tbl.push_back('{1'b0, 1'b1, 4'd0,  4'd5,  16'h0000, 2'b00, 8'h34, 16'h5634});
        tbl.push_back('{1'b1, 1'b0, 4'd3,  4'd0,  16'h0055, 2'b11, 8'h00, 16'h0000});
        tbl.push_back('{1'b1, 1'b1, 4'd3,  4'd3,  16'h00AA, 2'b11, 8'h55, 16'h00AA});
        tbl.push_back('{1'b0, 1'b1, 4'd0,  4'd3,  16'h0000, 2'b00, 8'hAA, 16'h00AA});
        tbl.push_back('{1'b1, 1'b1, 4'd3,  4'd3,  16'h1277, 2'b10, 8'hAA, 16'h12AA});
        tbl.push_back('{1'b0, 1'b1, 4'd0,  4'd3,  16'h0000, 2'b00, 8'hAA, 16'h12AA});
        tbl.push_back('{1'b1, 1'b1, 4'd4,  4'd2,  16'h0BEE, 2'b11, 8'h25, 16'hDA25});
        tbl.push_back('{1'b0, 1'b1, 4'd0,  4'd4,  16'h0000, 2'b00, 8'hEE, 16'h0BEE});
        tbl.push_back('{1'b0, 1'b1, 4'd0,  4'd0,  16'h0000, 2'b00, 8'h03, 16'hFC03});
        tbl.push_back('{1'b0, 1'b1, 4'd0,  4'd15, 16'h0000, 2'b00, 8'h02, 16'hFD02});
        tbl.push_back('{1'b0, 1'b1, 4'd0,  4'd9,  16'h0000, 2'b00, 8'h9C, 16'h639C});
        tbl.push_back('{1'b1, 1'b0, 4'd7,  4'd0,  16'h009C, 2'b11, 8'h00, 16'h0000});
        tbl.push_back('{1'b0, 1'b1, 4'd0,  4'd7,  16'h0000, 2'b00, 8'h9C, 16'h009C});

        foreach (tbl[v]) begin
            clear_q();
            wr_en   = tbl[v].wr;
            rd_en   = tbl[v].rd;
            wr_addr = tbl[v].wa;
            rd_addr = tbl[v].ra;
            din     = tbl[v].d;
            wr_be   = tbl[v].be;
            s = cyc + 1;
            tick();
            idle_inputs();
            repeat (3) tick();
            if (tbl[v].rd) begin
                chk($sformatf("vec%0d_count_a", v), qa_d.size(), 1);
                chk($sformatf("vec%0d_count_b", v), qb_d.size(), 1);
                chk($sformatf("vec%0d_data_a", v), qa_d.size() > 0 ? qa_d[0] : 16'hDEAD, {8'h00, tbl[v].ea});
                chk($sformatf("vec%0d_data_b", v), qb_d.size() > 0 ? qb_d[0] : 16'hDEAD, tbl[v].eb);
                chk($sformatf("vec%0d_lat_a", v), qa_c.size() > 0 ? qa_c[0] : -1, s);
                chk($sformatf("vec%0d_lat_b", v), qb_c.size() > 0 ? qb_c[0] : -1, s + 1);
            end else begin
                chk($sformatf("vec%0d_novalid_a", v), qa_d.size(), 0);
                chk($sformatf("vec%0d_novalid_b", v), qb_d.size(), 0);
            end
        end

        // Reset while a read of addr 7 is in flight
        clear_q();
        rd_en   = 1'b1;
        rd_addr = 4'd7;
        tick();
        idle_inputs();
        rst = 1'b0;
        tick();
        chk("flush_dout_a", dout_a, 8'h00);
        chk("flush_dout_b", dout_b, 16'h0000);
        chk("flush_valid_b", rd_valid_b, 1'b0);
        chk("flush_busy_b", init_busy_b, 1'b1);

        // Reset again part-way through the clear: it must restart from 0
        rst = 1'b1;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        run_init(na, nb, 1'b0);
        chk("reinit_cycles_a", na, 16);
        chk("reinit_cycles_b", nb, 16);
        tick();
        chk("flush_count_a", qa_d.size(), 1);
        chk("flush_data_a", qa_d.size() > 0 ? qa_d[0] : 16'hDEAD, 16'h009C);
        chk("flush_count_b", qb_d.size(), 0);
        stream_reads(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
